// File: rtl/control_pkg.sv
// Shared opcodes, control-bundle bit layout and forwarding encodings for the control pipeline.
package control_pkg;

  localparam int CTRL_W = 12;

  // Control bundle bit positions, MSB first
  localparam int B_REG_WRITE   = 11;
  localparam int B_MEM_TO_REG  = 10;
  localparam int B_MEM_READ    = 9;
  localparam int B_MEM_WRITE   = 8;
  localparam int B_BRANCH_EQ   = 7;
  localparam int B_BRANCH_NE   = 6;
  localparam int B_ALU_OP_HI   = 5;
  localparam int B_ALU_OP_LO   = 4;
  localparam int B_ALU_SRC     = 3;
  localparam int B_REG_DST     = 2;
  localparam int B_SHIFT_UPPER = 1;
  localparam int B_JUMP        = 0;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode-to-control-bundle table with illegal-opcode and rt-is-source flags.
module control_decode
  import control_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output logic [CTRL_W-1:0]   ctrl_o,
  output logic                illegal_o,
  output logic                rt_used_o
);

  always_comb begin
    ctrl_o    = '0;
    illegal_o = 1'b0;
    rt_used_o = 1'b0;
    case (opcode_i)
      OPCODE_W'(OP_LW): begin
        ctrl_o[B_MEM_READ]               = 1'b1;
        ctrl_o[B_MEM_TO_REG]             = 1'b1;
        ctrl_o[B_ALU_SRC]                = 1'b1;
        ctrl_o[B_REG_WRITE]              = 1'b1;
        ctrl_o[B_ALU_OP_HI:B_ALU_OP_LO]  = ALU_ADD;
      end
      OPCODE_W'(OP_SW): begin
        ctrl_o[B_MEM_WRITE]              = 1'b1;
        ctrl_o[B_ALU_SRC]                = 1'b1;
        ctrl_o[B_ALU_OP_HI:B_ALU_OP_LO]  = ALU_ADD;
        rt_used_o                        = 1'b1;
      end
      OPCODE_W'(OP_BEQ): begin
        ctrl_o[B_BRANCH_EQ]              = 1'b1;
        ctrl_o[B_ALU_OP_HI:B_ALU_OP_LO]  = ALU_BRANCH;
        rt_used_o                        = 1'b1;
      end
      OPCODE_W'(OP_BNE): begin
        ctrl_o[B_BRANCH_NE]              = 1'b1;
        ctrl_o[B_ALU_OP_HI:B_ALU_OP_LO]  = ALU_BRANCH;
        rt_used_o                        = 1'b1;
      end
      OPCODE_W'(OP_ADDI): begin
        ctrl_o[B_REG_WRITE]              = 1'b1;
        ctrl_o[B_ALU_SRC]                = 1'b1;
        ctrl_o[B_ALU_OP_HI:B_ALU_OP_LO]  = ALU_ADD;
      end
      OPCODE_W'(OP_RTYPE): begin
        ctrl_o[B_REG_WRITE]              = 1'b1;
        ctrl_o[B_REG_DST]                = 1'b1;
        ctrl_o[B_ALU_OP_HI:B_ALU_OP_LO]  = ALU_FUNCT;
        rt_used_o                        = 1'b1;
      end
      OPCODE_W'(OP_LUI): begin
        ctrl_o[B_REG_WRITE]              = 1'b1;
        ctrl_o[B_SHIFT_UPPER]            = 1'b1;
      end
      OPCODE_W'(OP_J): begin
        ctrl_o[B_JUMP]                   = 1'b1;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_pipeline.sv
// Pipelined control unit: decode, ID/EX-EX/MEM-MEM/WB control registers, hazard stall, flush, forwarding.
// Define CONTROL_PIPELINE_FORWARD_EN to enable EX operand forwarding (only load-use then stalls).
module control_pipeline
  import control_pkg::*;
#(
  parameter int OPCODE_W   = 6,
  parameter int REG_ADDR_W = 5,
  parameter int ZERO_REG   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [OPCODE_W-1:0]   id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ex_branch_taken,
  output logic                  stall,
  output logic                  flush_if_id,
  output logic                  jump_redirect,
  output logic [CTRL_W-1:0]     ex_ctrl,
  output logic [CTRL_W-1:0]     mem_ctrl,
  output logic [CTRL_W-1:0]     wb_ctrl,
  output logic [REG_ADDR_W-1:0] ex_dest,
  output logic [REG_ADDR_W-1:0] mem_dest,
  output logic [REG_ADDR_W-1:0] wb_dest,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  illegal_op
);

  localparam logic [REG_ADDR_W-1:0] ZERO_ADDR = REG_ADDR_W'(ZERO_REG);

  logic [CTRL_W-1:0]     dec_ctrl;
  logic                  dec_illegal;
  logic                  dec_rt_used;

  logic [CTRL_W-1:0]     ex_ctrl_q, mem_ctrl_q, wb_ctrl_q, ex_ctrl_d;
  logic [REG_ADDR_W-1:0] ex_dest_q, mem_dest_q, wb_dest_q, ex_dest_d;
  logic [REG_ADDR_W-1:0] ex_rs_q, ex_rt_q, ex_rs_d, ex_rt_d;
  logic                  illegal_q, illegal_d;
  logic [REG_ADDR_W-1:0] id_dest;
  logic                  ex_hit, load_use, hazard, bubble;

  control_decode #(
    .OPCODE_W (OPCODE_W)
  ) u_decode (
    .opcode_i  (id_opcode),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal),
    .rt_used_o (dec_rt_used)
  );

  // A producer blocks ID when its destination is one of the ID sources; the zero register never counts.
  function automatic logic reads_id(input logic [REG_ADDR_W-1:0] dest,
                                    input logic [REG_ADDR_W-1:0] rs,
                                    input logic [REG_ADDR_W-1:0] rt,
                                    input logic                  rt_used);
    return (dest != ZERO_ADDR) && ((dest == rs) || (rt_used && (dest == rt)));
  endfunction

  assign ex_hit   = reads_id(ex_dest_q, id_rs, id_rt, dec_rt_used);
  assign load_use = ex_ctrl_q[B_MEM_READ] && ex_hit;

`ifdef CONTROL_PIPELINE_FORWARD_EN
  assign hazard = load_use;
`else
  logic mem_hit;
  assign mem_hit = reads_id(mem_dest_q, id_rs, id_rt, dec_rt_used);
  assign hazard  = load_use || (ex_ctrl_q[B_REG_WRITE] && ex_hit)
                            || (mem_ctrl_q[B_REG_WRITE] && mem_hit);
`endif

  // A taken branch squashes ID anyway, so it overrides both the stall and a jump in ID.
  assign stall         = id_valid && hazard && !ex_branch_taken;
  assign jump_redirect = id_valid && dec_ctrl[B_JUMP] && !stall && !ex_branch_taken;
  assign flush_if_id   = ex_branch_taken || jump_redirect;
  assign bubble        = stall || ex_branch_taken || !id_valid;

  always_comb begin
    id_dest   = dec_ctrl[B_REG_DST] ? id_rd : id_rt;
    ex_ctrl_d = '0;
    ex_dest_d = '0;
    ex_rs_d   = '0;
    ex_rt_d   = '0;
    if (!bubble) begin
      ex_ctrl_d              = dec_ctrl;
      ex_ctrl_d[B_REG_WRITE] = dec_ctrl[B_REG_WRITE] && (id_dest != ZERO_ADDR);
      ex_dest_d              = id_dest;
      ex_rs_d                = id_rs;
      ex_rt_d                = id_rt;
    end
    illegal_d = id_valid && dec_illegal;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_ctrl_q  <= '0;
      mem_ctrl_q <= '0;
      wb_ctrl_q  <= '0;
      ex_dest_q  <= '0;
      mem_dest_q <= '0;
      wb_dest_q  <= '0;
      ex_rs_q    <= '0;
      ex_rt_q    <= '0;
      illegal_q  <= 1'b0;
    end else begin
      ex_ctrl_q  <= ex_ctrl_d;
      ex_dest_q  <= ex_dest_d;
      ex_rs_q    <= ex_rs_d;
      ex_rt_q    <= ex_rt_d;
      mem_ctrl_q <= ex_ctrl_q;
      mem_dest_q <= ex_dest_q;
      wb_ctrl_q  <= mem_ctrl_q;
      wb_dest_q  <= mem_dest_q;
      illegal_q  <= illegal_d;
    end
  end

`ifdef CONTROL_PIPELINE_FORWARD_EN
  logic [1:0][REG_ADDR_W-1:0] ex_src;
  logic [1:0][1:0]            fwd_sel;

  assign ex_src[0] = ex_rs_q;
  assign ex_src[1] = ex_rt_q;

  // EX/MEM holds the younger result, so it takes priority over MEM/WB.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign fwd_sel[gi] =
      (mem_ctrl_q[B_REG_WRITE] && (mem_dest_q == ex_src[gi]) && (mem_dest_q != ZERO_ADDR)) ? FWD_MEM :
      (wb_ctrl_q[B_REG_WRITE]  && (wb_dest_q  == ex_src[gi]) && (wb_dest_q  != ZERO_ADDR)) ? FWD_WB  :
                                                                                            FWD_RF;
  end

  assign fwd_a = fwd_sel[0];
  assign fwd_b = fwd_sel[1];
`else
  logic unused_ex_src;
  assign unused_ex_src = ^{ex_rs_q, ex_rt_q};
  assign fwd_a         = FWD_RF;
  assign fwd_b         = FWD_RF;
`endif

  assign ex_ctrl    = ex_ctrl_q;
  assign mem_ctrl   = mem_ctrl_q;
  assign wb_ctrl    = wb_ctrl_q;
  assign ex_dest    = ex_dest_q;
  assign mem_dest   = mem_dest_q;
  assign wb_dest    = wb_dest_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_control_pipeline.sv
// Scoreboard bench for control_pipeline: directed scenarios plus random stream against a slot-level model.
module tb_control_pipeline;
  import control_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        ex_branch_taken;
  logic        stall, flush_if_id, jump_redirect, illegal_op;
  logic [11:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic [4:0]  ex_dest, mem_dest, wb_dest;
  logic [1:0]  fwd_a, fwd_b;

  control_pipeline #(.OPCODE_W(6), .REG_ADDR_W(5), .ZERO_REG(0)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
    .stall(stall), .flush_if_id(flush_if_id), .jump_redirect(jump_redirect),
    .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .ex_dest(ex_dest), .mem_dest(mem_dest), .wb_dest(wb_dest),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] ctrl;
    logic [4:0]  dest;
  } slot_t;

  typedef struct packed {
    logic        stall, flush, jr, ill;
    logic [11:0] ex_c, mem_c, wb_c;
    logic [4:0]  ex_d, mem_d, wb_d;
    logic [1:0]  fa, fb;
  } exp_t;

  slot_t      m_ex, m_mem, m_wb;
  logic [4:0] m_rs, m_rt;
  logic       m_ill;
  exp_t       sb[$];
  int         n_vec = 0;
  int         n_bad = 0;
  int         txn   = 0;
  logic       last_stall = 1'b0;

  function automatic logic [11:0] ref_bundle(input logic [5:0] op, output logic legal);
    logic [11:0] b = '0;
    legal = 1'b1;
    case (op)
      OP_LW:    begin b[B_MEM_READ] = 1; b[B_MEM_TO_REG] = 1; b[B_ALU_SRC] = 1; b[B_REG_WRITE] = 1; end
      OP_SW:    begin b[B_MEM_WRITE] = 1; b[B_ALU_SRC] = 1; end
      OP_BEQ:   begin b[B_BRANCH_EQ] = 1; b[B_ALU_OP_LO +: 2] = 2'b01; end
      OP_BNE:   begin b[B_BRANCH_NE] = 1; b[B_ALU_OP_LO +: 2] = 2'b01; end
      OP_ADDI:  begin b[B_REG_WRITE] = 1; b[B_ALU_SRC] = 1; end
      OP_RTYPE: begin b[B_REG_WRITE] = 1; b[B_REG_DST] = 1; b[B_ALU_OP_LO +: 2] = 2'b10; end
      OP_LUI:   begin b[B_REG_WRITE] = 1; b[B_SHIFT_UPPER] = 1; end
      OP_J:     begin b[B_JUMP] = 1; end
      default:  legal = 1'b0;
    endcase
    return b;
  endfunction

  function automatic logic rt_is_src(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SW};
  endfunction

  function automatic logic needs(input logic [4:0] dest);
    return dest != 5'd0 && (dest == id_rs || (rt_is_src(id_opcode) && dest == id_rt));
  endfunction

  function automatic logic [1:0] fwd_of(input logic [4:0] src);
    if (m_mem.ctrl[B_REG_WRITE] && m_mem.dest == src && src != 5'd0) return 2'b10;
    if (m_wb.ctrl[B_REG_WRITE]  && m_wb.dest  == src && src != 5'd0) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t predict();
    exp_t        e;
    logic [11:0] b;
    logic        legal, haz;
    haz = m_ex.ctrl[B_MEM_READ] && needs(m_ex.dest);
`ifdef CONTROL_PIPELINE_FORWARD_EN
    e.fa = fwd_of(m_rs);
    e.fb = fwd_of(m_rt);
`else
    haz  = haz || (m_ex.ctrl[B_REG_WRITE] && needs(m_ex.dest))
               || (m_mem.ctrl[B_REG_WRITE] && needs(m_mem.dest));
    e.fa = 2'b00;
    e.fb = 2'b00;
`endif
    b       = ref_bundle(id_opcode, legal);
    e.stall = id_valid && haz && !ex_branch_taken;
    e.jr    = id_valid && b[B_JUMP] && !e.stall && !ex_branch_taken;
    e.flush = ex_branch_taken || e.jr;
    e.ill   = m_ill;
    e.ex_c  = m_ex.ctrl;  e.ex_d  = m_ex.dest;
    e.mem_c = m_mem.ctrl; e.mem_d = m_mem.dest;
    e.wb_c  = m_wb.ctrl;  e.wb_d  = m_wb.dest;
    return e;
  endfunction

  task automatic model_step();
    exp_t        e;
    logic [11:0] b;
    logic [4:0]  d;
    logic        legal;
    e     = predict();
    b     = ref_bundle(id_opcode, legal);
    m_wb  = m_mem;
    m_mem = m_ex;
    m_ill = id_valid && !legal;
    if (e.stall || ex_branch_taken || !id_valid) begin
      m_ex = '0; m_rs = '0; m_rt = '0;
    end else begin
      d = (id_opcode == OP_RTYPE) ? id_rd : id_rt;
      if (d == 5'd0) b[B_REG_WRITE] = 1'b0;
      m_ex = '{ctrl: b, dest: d};
      m_rs = id_rs;
      m_rt = id_rt;
    end
  endtask

  task automatic model_reset();
    m_ex = '0; m_mem = '0; m_wb = '0; m_rs = '0; m_rt = '0; m_ill = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s txn %0d: got %0h expected %0h", name, txn, act, exp);
    end
  endtask

  // Monitor: every cycle with a pending expectation is compared on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      txn++;
      $display("txn %0d: v=%b op=%h rs=%0d rt=%0d rd=%0d br=%b stall=%b flush=%b jr=%b ex=%h/%0d mem=%h/%0d wb=%h/%0d fwd=%b,%b ill=%b",
               txn, id_valid, id_opcode, id_rs, id_rt, id_rd, ex_branch_taken, stall, flush_if_id,
               jump_redirect, ex_ctrl, ex_dest, mem_ctrl, mem_dest, wb_ctrl, wb_dest, fwd_a, fwd_b, illegal_op);
      chk("stall",    32'(stall),         32'(e.stall));
      chk("flush",    32'(flush_if_id),   32'(e.flush));
      chk("jump_rd",  32'(jump_redirect), 32'(e.jr));
      chk("ex_ctrl",  32'(ex_ctrl),       32'(e.ex_c));
      chk("mem_ctrl", 32'(mem_ctrl),      32'(e.mem_c));
      chk("wb_ctrl",  32'(wb_ctrl),       32'(e.wb_c));
      chk("ex_dest",  32'(ex_dest),       32'(e.ex_d));
      chk("mem_dest", 32'(mem_dest),      32'(e.mem_d));
      chk("wb_dest",  32'(wb_dest),       32'(e.wb_d));
      chk("fwd_a",    32'(fwd_a),         32'(e.fa));
      chk("fwd_b",    32'(fwd_b),         32'(e.fb));
      chk("illegal",  32'(illegal_op),    32'(e.ill));
    end
  end

  task automatic issue(input logic v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic br);
    exp_t e;
    @(posedge clk);
    model_step();
    #1;
    id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd; ex_branch_taken = br;
    #1;
    e = predict();
    last_stall = e.stall;
    sb.push_back(e);
  endtask

  // Hold an instruction in ID for as long as the model says it is stalled.
  task automatic send(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic br);
    issue(1'b1, op, rs, rt, rd, br);
    for (int k = 0; k < 4 && last_stall; k++) issue(1'b1, op, rs, rt, rd, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) issue(1'b0, OP_RTYPE, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ops [10];
    ops = '{OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_RTYPE, OP_LUI, OP_J, 6'h3f, 6'h11};
    reset = 1'b1;
    id_valid = 1'b0; id_opcode = '0; id_rs = '0; id_rt = '0; id_rd = '0; ex_branch_taken = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    idle(1);
    send(OP_LW, 5'd1, 5'd2, 5'd0, 1'b0);       // load-use
    send(OP_RTYPE, 5'd2, 5'd4, 5'd3, 1'b0);
    idle(3);
    send(OP_RTYPE, 5'd1, 5'd1, 5'd5, 1'b0);    // RAW through EX/MEM
    send(OP_RTYPE, 5'd5, 5'd5, 5'd6, 1'b0);
    idle(3);
    send(OP_BEQ, 5'd1, 5'd2, 5'd0, 1'b0);      // branch in EX beats jump in ID
    issue(1'b1, OP_J, 5'd0, 5'd0, 5'd0, 1'b1);
    send(OP_J, 5'd0, 5'd0, 5'd0, 1'b0);
    idle(2);
    send(6'h3f, 5'd1, 5'd2, 5'd3, 1'b0);       // illegal opcode
    idle(2);
    send(OP_ADDI, 5'd1, 5'd0, 5'd9, 1'b0);     // write to zero register
    send(OP_RTYPE, 5'd0, 5'd0, 5'd7, 1'b0);
    idle(3);

    // Asynchronous reset in the middle of a load-use stall
    send(OP_LW, 5'd1, 5'd2, 5'd0, 1'b0);
    issue(1'b1, OP_RTYPE, 5'd2, 5'd2, 5'd3, 1'b0);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_ex_ctrl",  32'(ex_ctrl),    32'd0);
    chk("rst_mem_ctrl", 32'(mem_ctrl),   32'd0);
    chk("rst_ex_dest",  32'(ex_dest),    32'd0);
    chk("rst_illegal",  32'(illegal_op), 32'd0);
    chk("rst_stall",    32'(stall),      32'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    model_reset();
    #1 chk("rel_stall", 32'(stall), 32'd0);
    idle(3);

    for (int i = 0; i < 500; i++) begin
      logic br;
      br = ($urandom_range(0, 9) == 0);
      if (last_stall)
        issue(id_valid, id_opcode, id_rs, id_rt, id_rd, br);
      else
        issue($urandom_range(0, 7) != 0, ops[$urandom_range(0, 9)],
              ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), br);
    end
    idle(2);

    @(negedge clk);
    #1 chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/control_pipeline.md
Name: control_pipeline

Overview:
Parametrised successor to the single-cycle opcode decoder. It decodes the ID-stage opcode into a control bundle and carries that bundle through ID/EX, EX/MEM and MEM/WB registers. It also detects load-use and RAW hazards, inserts bubbles, flushes on a taken branch or jump, and flags illegal opcodes. It sits beside the 5-stage datapath and drives the stall, flush and per-stage control inputs.

Parameters:
- OPCODE_W, 6, opcode field width.
- REG_ADDR_W, 5, register-specifier width.
- ZERO_REG, 0, hard-wired zero register index. Writes to it are suppressed, and it never causes a hazard.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all pipeline registers.
- id_valid  in  1  IF/ID holds a real instruction.
- id_opcode  in  OPCODE_W  ID-stage opcode.
- id_rs, id_rt, id_rd  in  REG_ADDR_W each  ID-stage register specifiers.
- ex_branch_taken  in  1  branch in EX resolved taken this cycle.
- stall  out  1  hold PC and IF/ID (combinational).
- flush_if_id  out  1  squash IF/ID (combinational).
- jump_redirect  out  1  redirect PC to the jump target (combinational).
- ex_ctrl, mem_ctrl, wb_ctrl  out  CTRL_W each  registered control bundle per stage.
- ex_dest, mem_dest, wb_dest  out  REG_ADDR_W each  registered destination register.
- fwd_a, fwd_b  out  2 each  EX operand forwarding selects.
- illegal_op  out  1  registered one-cycle pulse.

Behaviour:
- Bundle (CTRL_W=12) fields: reg_write, mem_to_reg, mem_read, mem_write, branch_eq, branch_ne, alu_op[1:0], alu_src, reg_dst, shift_upper, jump.
- Decode table:
  - LW 100011: mem_read, mem_to_reg, alu_src, reg_write, alu_op=00.
  - SW 101011: mem_write, alu_src, alu_op=00.
  - BEQ 000100: branch_eq, alu_op=01.
  - BNE 000101: branch_ne, alu_op=01.
  - ADDI 001000: reg_write, alu_src, alu_op=00.
  - R-type 000000: reg_write, reg_dst, alu_op=10.
  - LUI 001111: reg_write, shift_upper.
  - J 000010: jump only; reg_write=0.
- Unknown opcode with id_valid: decodes to an all-zero bundle; illegal_op pulses on the next edge.
- Destination: dest = reg_dst ? id_rd : id_rt. If dest==ZERO_REG, reg_write is forced to 0.
- rt is a source for R-type, BEQ, BNE and SW only.
- load_use: ex_ctrl.mem_read && ex_dest!=ZERO_REG && (ex_dest==id_rs || (rt is a source && ex_dest==id_rt)).
- stall = id_valid && load_use && !ex_branch_taken.
- flush_if_id = ex_branch_taken || jump_redirect.
- jump_redirect = id_valid && decoded jump && !stall && !ex_branch_taken.
- Per rising edge:
  - ID/EX loads a bubble (all zero, dest=0) if stall, ex_branch_taken or !id_valid; otherwise it loads the decoded bundle plus id_rs/id_rt.
  - EX/MEM and MEM/WB always advance: mem_*<=ex_*, wb_*<=mem_*.
- Latency: the bundle appears on ex_ctrl 1 cycle after ID, mem_ctrl after 2, wb_ctrl after 3.
- Branch in EX plus jump in ID in the same cycle: the branch wins. The jump is bubbled, jump_redirect=0, flush_if_id=1.
- Register file writes in the first half-cycle, so the WB stage never causes a hazard.
- Reset, at any time including mid-stall: every *_ctrl, *_dest, registered rs/rt and illegal_op go to 0. The combinational outputs therefore evaluate with an empty pipeline.

Optional Feature:
Macro: CONTROL_PIPELINE_FORWARD_EN.
- Defined:
  - fwd_a (rs) and fwd_b (rt) select 10 when mem_ctrl.reg_write && mem_dest==ex_src && mem_dest!=ZERO_REG.
  - Otherwise they select 01 when the same test passes on the wb stage.
  - Otherwise they select 00. EX/MEM has priority over MEM/WB.
  - Only load_use stalls.
- Undefined:
  - fwd_a and fwd_b are tied to 00.
  - stall additionally asserts when ex_ctrl.reg_write or mem_ctrl.reg_write matches an ID source in the same way as load_use. The same ex_branch_taken suppression applies.

Decomposition:
- Package control_pkg holds:
  - the opcode localparams;
  - CTRL_W and the bundle bit indices;
  - the fwd encodings FWD_RF=00, FWD_MEM=10, FWD_WB=01.
- Sub-module control_decode holds the combinational opcode-to-bundle table, the illegal flag and the rt-used flag. control_pipeline holds the registers, hazard logic and forwarding.

Test Plan:
1. LW $2 into ID, then ADD $3,$2,$4 next cycle -> stall=1 for exactly one cycle, one zero bundle on ex_ctrl, the ADD reaches ex_ctrl a cycle later. With FORWARD_EN, fwd_a=01 for that ADD in EX.
2. ADD $5,$1,$1 then SUB-type R $6,$5,$5 -> with FORWARD_EN: no stall, fwd_a=fwd_b=10. Without it: stall=1 for two cycles.
3. BEQ in EX with ex_branch_taken=1 while J is in ID -> flush_if_id=1, jump_redirect=0, next ex_ctrl=0.
4. Opcode 111111 with id_valid=1 -> illegal_op=1 for one cycle, ex_ctrl=0.
5. ADDI with rt=0 -> ex_ctrl.reg_write=0. A following ADD reading $0 -> no stall, fwd=00.
6. Reset asserted mid-stall on a non-clock edge -> all registered outputs 0 immediately, stall=0 after release.
